// File: rtl/relu_activation_layer.sv
// ReLU activation stage: streams NUMBER_OF_NODE binary32 sums out of the
// hidden RAM, applies ReLU bitwise and writes value + derivative bit.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous reset, ACTIVE-HIGH
//   i_valid    - start pulse, sampled only in IDLE
//   o_rd_addr  - hidden RAM read address (data returns one cycle later)
//   i_rd_data  - hidden RAM read data
//   o_wr_en    - activation RAM write enable
//   o_wr_addr  - activation RAM write address
//   o_wr_data  - activation value
//   o_wr_deriv - ReLU derivative bit (input strictly positive)
//   o_busy     - high from the cycle after start through the done cycle
//   o_valid    - one-cycle done pulse
//
// Optional feature macro: LEAKY_RELU_EN (negative finite inputs are scaled
// by 2**-LEAK_SHIFT via exponent subtraction instead of being zeroed).
module relu_activation_layer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 5,
    parameter int NUMBER_OF_NODE = 32,
    parameter int LEAK_SHIFT     = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic [ADDRESS_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]    i_rd_data,
    output logic                     o_wr_en,
    output logic [ADDRESS_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0]    o_wr_data,
    output logic                     o_wr_deriv,
    output logic                     o_busy,
    output logic                     o_valid
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Terminal address compared exactly, so the counter never wraps even
    // when NUMBER_OF_NODE fills the whole address space.
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR =
        ADDRESS_WIDTH'(NUMBER_OF_NODE - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     rd_vld;
    logic                     p1_vld;
    logic [ADDRESS_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0]    act;
    logic                     deriv;
    logic                     sign;

    assign sign = i_rd_data[DATA_WIDTH-1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_vld    = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_vld = 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end
            end
            // Leave once the final read has moved into the write register.
            DRAIN: begin
                if (!p1_vld) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_addr <= '0;
        end else if (state == READ && rd_addr != LAST_ADDR) begin
            rd_addr <= rd_addr + ADDRESS_WIDTH'(1);
        end else if (state == DONE) begin
            rd_addr <= '0;
        end
    end

    // ReLU on the raw bit pattern: any set sign bit kills the value, and
    // +inf / +NaN pass through like any other positive pattern.
`ifdef LEAKY_RELU_EN
    logic [7:0] expo;
    assign expo = i_rd_data[DATA_WIDTH-2 -: 8];

    always_comb begin
        act   = '0;
        deriv = 1'b0;
        if (!sign) begin
            act   = i_rd_data;
            deriv = |i_rd_data;
        end else if (&expo) begin
            act = i_rd_data;
        end else if (expo <= 8'(LEAK_SHIFT)) begin
            act = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            act = {1'b1, expo - 8'(LEAK_SHIFT),
                   i_rd_data[DATA_WIDTH-10:0]};
        end
    end
`else
    always_comb begin
        act   = '0;
        deriv = 1'b0;
        if (!sign) begin
            act   = i_rd_data;
            deriv = |i_rd_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            p1_vld     <= 1'b0;
            p1_addr    <= '0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_wr_deriv <= 1'b0;
        end else begin
            p1_vld  <= rd_vld;
            p1_addr <= rd_addr;
            o_wr_en <= p1_vld;
            if (p1_vld) begin
                o_wr_addr  <= p1_addr;
                o_wr_data  <= act;
                o_wr_deriv <= deriv;
            end
        end
    end

    assign o_rd_addr = rd_addr;
    assign o_busy    = (state != IDLE);
    assign o_valid   = (state == DONE);

endmodule

// File: tb/tb_relu_activation_layer.sv
// Directed bench for relu_activation_layer: N=32 instance plus N=1 corner.
// Cycle 0 is the cycle in which i_valid is presented.
module tb_relu_activation_layer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv  = 1'b0;
    logic        iv1 = 1'b0;

    logic [4:0]  ra, wa;
    logic [31:0] rd, wd;
    logic        we, wder, busy, vld;

    logic [0:0]  ra1, wa1;
    logic [31:0] rd1, wd1;
    logic        we1, wder1, busy1, vld1;

    logic [31:0] ram [32];
    logic [31:0] ram1 [2];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int pulses[$];

    logic        ev_wr   [64];
    logic [4:0]  ev_addr [64];
    logic [31:0] ev_data [64];
    logic        ev_der  [64];
    logic        ev_val  [64];
    logic        ev_busy [64];
    logic [4:0]  ev_ra   [64];
    logic        e1_wr   [64];
    logic [31:0] e1_data [64];
    logic        e1_der  [64];
    logic        e1_val  [64];
    logic        e1_busy [64];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd  <= ram[ra];
        rd1 <= ram1[ra1];
    end

    relu_activation_layer dut (
        .clk(clk), .rst_n(rst), .i_valid(iv),
        .o_rd_addr(ra), .i_rd_data(rd),
        .o_wr_en(we), .o_wr_addr(wa), .o_wr_data(wd),
        .o_wr_deriv(wder), .o_busy(busy), .o_valid(vld)
    );

    relu_activation_layer #(
        .ADDRESS_WIDTH(1), .NUMBER_OF_NODE(1)
    ) dut1 (
        .clk(clk), .rst_n(rst), .i_valid(iv1),
        .o_rd_addr(ra1), .i_rd_data(rd1),
        .o_wr_en(we1), .o_wr_addr(wa1), .o_wr_data(wd1),
        .o_wr_deriv(wder1), .o_busy(busy1), .o_valid(vld1)
    );

    task automatic record(input int c);
        ev_wr[c]   = we;
        ev_addr[c] = wa;
        ev_data[c] = wd;
        ev_der[c]  = wder;
        ev_val[c]  = vld;
        ev_busy[c] = busy;
        ev_ra[c]   = ra;
        e1_wr[c]   = we1;
        e1_data[c] = wd1;
        e1_der[c]  = wder1;
        e1_val[c]  = vld1;
        e1_busy[c] = busy1;
    endtask

    // Pulses i_valid at cycle 0 and at every cycle listed in pulses;
    // called #1 after a rising edge.
    task automatic collect(input int ncyc, input bit sel);
        if (sel) iv1 = 1'b1;
        else     iv  = 1'b1;
        record(0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            iv  = 1'b0;
            iv1 = 1'b0;
            record(c);
            foreach (pulses[j]) begin
                if (pulses[j] == c) begin
                    if (sel) iv1 = 1'b1;
                    else     iv  = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (we !== 1'b0 || we1 !== 1'b0)
                $display("FAIL reset_wr_en cyc%0d got %b/%b want 0", i, we, we1);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({ra, wa, wd, wder, busy, vld} !== '0)
            $display("FAIL reset_outs got %h want 0", {ra, wa, wd, wder, busy, vld});
        else pass_cnt++;
        chk_cnt++;
        if ({ra1, wa1, wd1, wder1, busy1, vld1} !== '0)
            $display("FAIL reset_outs_n1 got %h want 0",
                     {ra1, wa1, wd1, wder1, busy1, vld1});
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram;
        logic [31:0] pat [8];
        pat = '{32'h3FC00000, 32'hC0000000, 32'h00000000, 32'h80000000,
                32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000001};
        for (int k = 0; k < 32; k++) ram[k] = pat[k % 8];
        ram[31] = 32'h83800000;
    endtask

    // Checks a full 32-node run starting at cycle 0 against hand values.
    task automatic check_run(input string tag);
        logic [31:0] xd [8];
        logic [7:0]  xder;
        logic [31:0] exp_d;
        int k;
`ifdef LEAKY_RELU_EN
        xd = '{32'h3FC00000, 32'hBC800000, 32'h00000000, 32'h80000000,
               32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000001};
`else
        xd = '{32'h3FC00000, 32'h00000000, 32'h00000000, 32'h00000000,
               32'h7F800000, 32'h00000000, 32'h7FC00001, 32'h00000001};
`endif
        xder = 8'b1101_0001;
        for (int c = 0; c <= 40; c++) begin
            chk_cnt++;
            if (ev_wr[c] !== (c >= 3 && c <= 34))
                $display("FAIL %s wr_en c%0d got %b", tag, c, ev_wr[c]);
            else pass_cnt++;
            chk_cnt++;
            if (ev_val[c] !== (c == 35))
                $display("FAIL %s valid c%0d got %b", tag, c, ev_val[c]);
            else pass_cnt++;
            if (c >= 3 && c <= 34) begin
                k = c - 3;
`ifdef LEAKY_RELU_EN
                exp_d = (k == 31) ? 32'h80000000 : xd[k % 8];
`else
                exp_d = (k == 31) ? 32'h00000000 : xd[k % 8];
`endif
                chk_cnt++;
                if (ev_addr[c] !== 5'(k))
                    $display("FAIL %s wr_addr c%0d got %0d want %0d",
                             tag, c, ev_addr[c], k);
                else pass_cnt++;
                chk_cnt++;
                if (ev_data[c] !== exp_d)
                    $display("FAIL %s wr_data k%0d got %h want %h",
                             tag, k, ev_data[c], exp_d);
                else pass_cnt++;
                chk_cnt++;
                if (ev_der[c] !== (k != 31 && xder[k % 8]))
                    $display("FAIL %s deriv k%0d got %b", tag, k, ev_der[c]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mixed;
        fill_ram();
        pulses = {};
        collect(40, 1'b0);
        check_run("mixed");
        for (int c = 1; c <= 33; c++) begin
            chk_cnt++;
            if (ev_ra[c] !== 5'((c > 32) ? 31 : c - 1))
                $display("FAIL rd_addr c%0d got %0d", c, ev_ra[c]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (ev_ra[36] !== 5'd0)
            $display("FAIL rd_addr_idle got %0d want 0", ev_ra[36]);
        else pass_cnt++;
    endtask

    task automatic test_busy;
        int nw, nv;
        pulses = {5, 35};
        collect(45, 1'b0);
        nw = 0;
        nv = 0;
        for (int c = 0; c <= 45; c++) begin
            if (ev_wr[c])  nw++;
            if (ev_val[c]) nv++;
            chk_cnt++;
            if (ev_busy[c] !== (c >= 1 && c <= 35))
                $display("FAIL busy c%0d got %b", c, ev_busy[c]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (nw != 32) $display("FAIL busy_writes got %0d want 32", nw);
        else pass_cnt++;
        chk_cnt++;
        if (nv != 1 || ev_val[35] !== 1'b1)
            $display("FAIL busy_valid got %0d pulses want 1 at 35", nv);
        else pass_cnt++;
        pulses = {};
    endtask

    task automatic test_abort;
        collect(9, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({ra, we, busy, vld} !== '0)
            $display("FAIL abort_outs got %h want 0", {ra, we, busy, vld});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (we !== 1'b0 || vld !== 1'b0)
                $display("FAIL abort_hold got wr=%b v=%b want 0", we, vld);
            else pass_cnt++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        collect(40, 1'b0);
        check_run("abort");
    endtask

    task automatic test_back_to_back;
        ram1[0] = 32'h40490FDB;
        ram1[1] = 32'hBF800000;
        pulses = {5};
        collect(12, 1'b1);
        for (int c = 0; c <= 12; c++) begin
            chk_cnt++;
            if (e1_wr[c] !== (c == 3 || c == 8))
                $display("FAIL n1 wr_en c%0d got %b", c, e1_wr[c]);
            else pass_cnt++;
            chk_cnt++;
            if (e1_val[c] !== (c == 4 || c == 9))
                $display("FAIL n1 valid c%0d got %b", c, e1_val[c]);
            else pass_cnt++;
            chk_cnt++;
            if (e1_busy[c] !== ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)))
                $display("FAIL n1 busy c%0d got %b", c, e1_busy[c]);
            else pass_cnt++;
            if (c == 3 || c == 8) begin
                chk_cnt++;
                if (e1_data[c] !== 32'h40490FDB || e1_der[c] !== 1'b1)
                    $display("FAIL n1 data c%0d got %h d%b want 40490fdb d1",
                             c, e1_data[c], e1_der[c]);
                else pass_cnt++;
            end
            chk_cnt++;
            if (ev_wr[c] !== 1'b0)
                $display("FAIL n1 other_dut_wr c%0d got 1", c);
            else pass_cnt++;
        end
        pulses = {};
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_busy();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
